// File: rtl/predecode_pkg.sv
// Shared widths, LoongArch opcode constants and bus payload layouts for the pre-decode stage.
package predecode_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned FPD_BUS_W     = 75;
  localparam int unsigned PREDICT_BUS_W = 33;
  localparam int unsigned PDD_BUS_W     = 107;

  localparam logic [5:0] OP_JIRL = 6'b010011;
  localparam logic [5:0] OP_B    = 6'b010100;
  localparam logic [5:0] OP_BL   = 6'b010101;
  localparam logic [5:0] OP_BEQ  = 6'b010110;
  localparam logic [5:0] OP_BNE  = 6'b010111;
  localparam logic [5:0] OP_BLT  = 6'b011000;
  localparam logic [5:0] OP_BGE  = 6'b011001;
  localparam logic [5:0] OP_BLTU = 6'b011010;
  localparam logic [5:0] OP_BGEU = 6'b011011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            req;
    logic            ex;
    logic [7:0]      ecode;
    logic            esubcode;
  } fpd_bus_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex;
    logic [7:0]      ecode;
    logic            esubcode;
  } pdd_bus_t;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } predict_bus_t;

endpackage

// File: rtl/br_predecode.sv
// Static direction/target prediction for LoongArch direct branches; purely combinational.
module br_predecode
  import predecode_pkg::*;
#(
  parameter bit STATIC_BTFN    = 1'b1,
  parameter bit PREDICT_UNCOND = 1'b1
) (
  input  logic [XLEN-1:0] pc,
  input  logic [31:0]     inst,
  input  logic            ex,
  output logic            is_branch,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target
);

  logic [5:0]      op;
  logic            is_uncond;
  logic            is_cond;
  logic [XLEN-1:0] off_uncond;
  logic [XLEN-1:0] off_cond;
  logic [XLEN-1:0] br_pc;
  logic [XLEN-1:0] seq_pc;

  always_comb begin
    op         = inst[31:26];
    is_uncond  = (op == OP_B) || (op == OP_BL);
    is_cond    = (op == OP_BEQ)  || (op == OP_BNE) || (op == OP_BLT) ||
                 (op == OP_BGE)  || (op == OP_BLTU) || (op == OP_BGEU);
    // JIRL counts as a branch but its register target cannot be known here
    is_branch  = is_uncond || is_cond || (op == OP_JIRL);

    off_uncond = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
    off_cond   = {{14{inst[25]}}, inst[25:10], 2'b00};

    // backward-taken / forward-not-taken keys off the offset sign bit
    pred_taken = !ex && ((is_uncond && PREDICT_UNCOND) ||
                         (is_cond && STATIC_BTFN && inst[25]));

    br_pc       = pc + (is_uncond ? off_uncond : off_cond);
    seq_pc      = pc + XLEN'(4);
    pred_target = pred_taken ? br_pc : seq_pc;
  end

endmodule

// File: rtl/predecode.sv
// Pre-decode pipeline stage: holds one fetched instruction, attaches a static branch
// prediction, redirects fetch on predicted-taken branches and drops wrong-path fetches.
module predecode
  import predecode_pkg::*;
#(
  parameter bit STATIC_BTFN    = 1'b1,
  parameter bit PREDICT_UNCOND = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     FpD_valid,
  input  logic [FPD_BUS_W-1:0]     FpD_BUS,
  output logic                     pD_allowin,
  input  logic                     D_allowin,
  input  logic                     flush,
  input  logic                     predict_error,
  output logic [PREDICT_BUS_W-1:0] predict_BUS,
  output logic                     pDD_valid,
  output logic [PDD_BUS_W-1:0]     pDD_BUS
);

  fpd_bus_t        fpd;
  pdd_bus_t        pdd_q;
  predict_bus_t    pred_q;
  logic            pd_valid;
  logic            expect_valid;
  logic [XLEN-1:0] expect_pc;

  logic            bp_is_branch;
  logic            bp_taken;
  logic [XLEN-1:0] bp_target;

  logic            flush_any;
  logic            accept;
  logic            wrong_path;
  logic            unused_ok;

  assign fpd        = fpd_bus_t'(FpD_BUS);
  assign flush_any  = flush | predict_error;
  assign pD_allowin = !pd_valid || D_allowin;
  assign accept     = FpD_valid && pD_allowin;
  assign wrong_path = expect_valid && (fpd.pc != expect_pc);
  assign unused_ok  = &{1'b0, fpd.req, bp_is_branch};

  br_predecode #(
    .STATIC_BTFN   (STATIC_BTFN),
    .PREDICT_UNCOND(PREDICT_UNCOND)
  ) u_br (
    .pc         (fpd.pc),
    .inst       (fpd.inst),
    .ex         (fpd.ex),
    .is_branch  (bp_is_branch),
    .pred_taken (bp_taken),
    .pred_target(bp_target)
  );

  // Pipeline register, wrong-path tracker and one-shot redirect pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pd_valid     <= 1'b0;
      pdd_q        <= '0;
      pred_q       <= '0;
      expect_valid <= 1'b0;
      expect_pc    <= '0;
    end else begin
      pred_q <= '0;
      if (flush_any) begin
        pd_valid     <= 1'b0;
        expect_valid <= 1'b0;
      end else if (accept) begin
        pd_valid <= !wrong_path;
        if (!wrong_path) begin
          pdd_q.pc          <= fpd.pc;
          pdd_q.inst        <= fpd.inst;
          pdd_q.pred_taken  <= bp_taken;
          pdd_q.pred_target <= bp_target;
          pdd_q.ex          <= fpd.ex;
          pdd_q.ecode       <= fpd.ecode;
          pdd_q.esubcode    <= fpd.esubcode;
          expect_valid      <= 1'b1;
          expect_pc         <= bp_target;
          if (bp_taken) begin
            pred_q.taken  <= 1'b1;
            pred_q.target <= bp_target;
          end
        end
      end else if (D_allowin) begin
        pd_valid <= 1'b0;
      end
    end
  end

  assign pDD_valid   = pd_valid;
  assign pDD_BUS     = pdd_q;
  assign predict_BUS = pred_q;

endmodule

// File: tb/tb_predecode.sv
// Directed self-checking bench for the predecode stage.
module tb_predecode;

  logic         clk;
  logic         rst;
  logic         FpD_valid;
  logic [74:0]  FpD_BUS;
  logic         pD_allowin;
  logic         D_allowin;
  logic         flush;
  logic         predict_error;
  logic [32:0]  predict_BUS;
  logic         pDD_valid;
  logic [106:0] pDD_BUS;

  int n_vec;
  int n_err;

  predecode dut (
    .clk          (clk),
    .rst          (rst),
    .FpD_valid    (FpD_valid),
    .FpD_BUS      (FpD_BUS),
    .pD_allowin   (pD_allowin),
    .D_allowin    (D_allowin),
    .flush        (flush),
    .predict_error(predict_error),
    .predict_BUS  (predict_BUS),
    .pDD_valid    (pDD_valid),
    .pDD_BUS      (pDD_BUS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [106:0] obs, input logic [106:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [106:0] mk_pdd(input logic [31:0] pc, input logic [31:0] inst,
                                          input logic tk, input logic [31:0] tgt,
                                          input logic ex, input logic [7:0] ec, input logic es);
    return {pc, inst, tk, tgt, ex, ec, es};
  endfunction

  // present one instruction for a single clock edge
  task automatic send(input logic [31:0] pc, input logic [31:0] inst,
                      input logic ex, input logic [7:0] ec, input logic es);
    FpD_valid = 1'b1;
    FpD_BUS   = {pc, inst, 1'b1, ex, ec, es};
    cycle();
    FpD_valid = 1'b0;
  endtask

  task automatic flush_cycle(input logic use_pe);
    FpD_valid     = 1'b0;
    flush         = !use_pe;
    predict_error = use_pe;
    cycle();
    flush         = 1'b0;
    predict_error = 1'b0;
  endtask

  localparam logic [31:0] NOP = 32'h02800000;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; FpD_valid = 1'b0; FpD_BUS = '0; D_allowin = 1'b1;
    flush = 1'b0; predict_error = 1'b0;
    cycle(); cycle();
    chk("rst_allowin", 107'(pD_allowin), 107'(1));
    chk("rst_valid",   107'(pDD_valid),  107'(0));
    chk("rst_bus",     pDD_BUS,          107'(0));
    chk("rst_pred",    107'(predict_BUS), 107'(0));
    rst = 1'b0;
    cycle();

    // plain instruction, first after reset
    send(32'h1c000000, NOP, 1'b0, 8'h00, 1'b0);
    chk("nop_valid", 107'(pDD_valid), 107'(1));
    chk("nop_bus", pDD_BUS, mk_pdd(32'h1c000000, NOP, 1'b0, 32'h1c000004, 1'b0, 8'h00, 1'b0));
    chk("nop_pred", 107'(predict_BUS), 107'(0));
    flush_cycle(1'b0);
    chk("flush_valid", 107'(pDD_valid), 107'(0));

    // B +0x40 predicted taken, wrong-path drop, then correct path kept
    send(32'h1c000100, 32'h50004000, 1'b0, 8'h00, 1'b0);
    chk("b_bus", pDD_BUS, mk_pdd(32'h1c000100, 32'h50004000, 1'b1, 32'h1c000140, 1'b0, 8'h00, 1'b0));
    chk("b_pred", 107'(predict_BUS), 107'({1'b1, 32'h1c000140}));
    send(32'h1c000104, NOP, 1'b0, 8'h00, 1'b0);
    chk("wp_drop_valid", 107'(pDD_valid), 107'(0));
    chk("wp_drop_pred", 107'(predict_BUS), 107'(0));
    send(32'h1c000140, NOP, 1'b0, 8'h00, 1'b0);
    chk("tgt_kept_valid", 107'(pDD_valid), 107'(1));
    chk("tgt_kept_bus", pDD_BUS, mk_pdd(32'h1c000140, NOP, 1'b0, 32'h1c000144, 1'b0, 8'h00, 1'b0));

    // BNE backward taken, BNE forward not taken
    flush_cycle(1'b0);
    send(32'h1c000200, 32'h5ffff800, 1'b0, 8'h00, 1'b0);
    chk("bne_back_bus", pDD_BUS, mk_pdd(32'h1c000200, 32'h5ffff800, 1'b1, 32'h1c0001f8, 1'b0, 8'h00, 1'b0));
    chk("bne_back_pred", 107'(predict_BUS), 107'({1'b1, 32'h1c0001f8}));
    flush_cycle(1'b1);
    chk("pe_flush_valid", 107'(pDD_valid), 107'(0));
    send(32'h1c000200, 32'h5c000800, 1'b0, 8'h00, 1'b0);
    chk("bne_fwd_bus", pDD_BUS, mk_pdd(32'h1c000200, 32'h5c000800, 1'b0, 32'h1c000204, 1'b0, 8'h00, 1'b0));
    chk("bne_fwd_pred", 107'(predict_BUS), 107'(0));
    send(32'h1c000208, NOP, 1'b0, 8'h00, 1'b0);
    chk("fwd_wp_drop", 107'(pDD_valid), 107'(0));
    send(32'h1c000204, NOP, 1'b0, 8'h00, 1'b0);
    chk("fwd_seq_kept", 107'(pDD_valid), 107'(1));

    // BL held under decode stall: bus stable, single redirect pulse
    send(32'h1c000208, 32'h54008000, 1'b0, 8'h00, 1'b0);
    chk("bl_pred", 107'(predict_BUS), 107'({1'b1, 32'h1c000288}));
    D_allowin = 1'b0;
    FpD_valid = 1'b1;
    FpD_BUS   = {32'h1c000288, NOP, 1'b1, 1'b0, 8'h00, 1'b0};
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_bus", pDD_BUS, mk_pdd(32'h1c000208, 32'h54008000, 1'b1, 32'h1c000288, 1'b0, 8'h00, 1'b0));
      chk("stall_allowin", 107'(pD_allowin), 107'(0));
      chk("stall_pred", 107'(predict_BUS), 107'(0));
    end
    D_allowin = 1'b1;
    cycle();
    FpD_valid = 1'b0;
    chk("unstall_bus", pDD_BUS, mk_pdd(32'h1c000288, NOP, 1'b0, 32'h1c00028c, 1'b0, 8'h00, 1'b0));
    chk("unstall_pred", 107'(predict_BUS), 107'(0));

    // taken BEQ arriving together with a flush is dropped
    flush = 1'b1;
    send(32'h1c00028c, 32'h5bfffc00, 1'b0, 8'h00, 1'b0);
    flush = 1'b0;
    chk("beq_flush_valid", 107'(pDD_valid), 107'(0));
    chk("beq_flush_pred", 107'(predict_BUS), 107'(0));
    send(32'h1c000500, NOP, 1'b0, 8'h00, 1'b0);
    chk("post_flush_kept", 107'(pDD_valid), 107'(1));

    // excepting B is forwarded unpredicted
    send(32'h1c000504, 32'h50004000, 1'b1, 8'h08, 1'b1);
    chk("ex_bus", pDD_BUS, mk_pdd(32'h1c000504, 32'h50004000, 1'b0, 32'h1c000508, 1'b1, 8'h08, 1'b1));
    chk("ex_pred", 107'(predict_BUS), 107'(0));

    // target wraps modulo 2^32
    flush_cycle(1'b0);
    send(32'hfffffffc, 32'h50000800, 1'b0, 8'h00, 1'b0);
    chk("wrap_pred", 107'(predict_BUS), 107'({1'b1, 32'h00000004}));

    // JIRL is never predicted even with a negative offset field
    send(32'h00000004, 32'h4ffff800, 1'b0, 8'h00, 1'b0);
    chk("jirl_bus", pDD_BUS, mk_pdd(32'h00000004, 32'h4ffff800, 1'b0, 32'h00000008, 1'b0, 8'h00, 1'b0));
    chk("jirl_pred", 107'(predict_BUS), 107'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
